// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types and defaults for the pixel scan sequencer and its axis counters.
package pixel_scan_sequencer_pkg;

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned H_RES_DEFAULT = 800;
    localparam int unsigned V_RES_DEFAULT = 600;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pixel_coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/pixel_axis_counter.sv
// One raster axis: counts 0..MAX, wrapping to 0; wrap flags the advance out of MAX.
module pixel_axis_counter
    import pixel_scan_sequencer_pkg::*;
#(
    parameter int unsigned MAX = 1023
) (
    input  logic   clk_i,
    input  logic   en_i,
    input  logic   clr_i,
    output coord_t count_o,
    output logic   wrap_o
);

    localparam coord_t MAX_C = coord_t'(MAX);

    coord_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == MAX_C) ? '0 : count_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign wrap_o  = en_i && (count_q == MAX_C);

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Raster-order pixel coordinate generator with pipeline drain and frame-done signalling.
module pixel_scan_sequencer
    import pixel_scan_sequencer_pkg::*;
#(
    parameter int unsigned H_RES        = H_RES_DEFAULT,
    parameter int unsigned V_RES        = V_RES_DEFAULT,
    parameter int unsigned PIPE_LATENCY = 8,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              pixel_valid,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count
);

    if (H_RES > 1024 || V_RES > 1024) begin : g_res_check
        $error("pixel_scan_sequencer: H_RES and V_RES must not exceed 1024");
    end
    if (PIPE_LATENCY < 1) begin : g_lat_check
        $error("pixel_scan_sequencer: PIPE_LATENCY must be at least 1");
    end

    localparam coord_t            H_MAX      = coord_t'(H_RES - 1);
    localparam int unsigned       DRAIN_W    = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LATENCY - 1);

    scan_state_t        state_q;
    logic               valid_q, sof_q, eol_q, busy_q, done_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic [DRAIN_W-1:0] drain_q;

    pixel_coord_t coord;
    coord_t       x_nxt;
    logic         start_ok, abort_ok, scan_adv, cnt_clr;
    logic         x_wrap, y_wrap;

    always_comb begin
        start_ok = (state_q == IDLE) && start;
        abort_ok = abort && ((state_q == SCAN) || (state_q == DRAIN));
        scan_adv = (state_q == SCAN) && !stall && !abort;
        cnt_clr  = rst || start_ok || abort_ok;
        x_nxt    = x_wrap ? '0 : coord.x + coord_t'(1);
    end

    // y advances on x wrap; y wrap is therefore the edge that leaves the last pixel
    pixel_axis_counter #(.MAX(H_RES - 1)) u_x_cnt (
        .clk_i  (sysclk),
        .en_i   (scan_adv),
        .clr_i  (cnt_clr),
        .count_o(coord.x),
        .wrap_o (x_wrap)
    );

    pixel_axis_counter #(.MAX(V_RES - 1)) u_y_cnt (
        .clk_i  (sysclk),
        .en_i   (x_wrap),
        .clr_i  (cnt_clr),
        .count_o(coord.y),
        .wrap_o (y_wrap)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            drain_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        sof_q   <= 1'b1;
                        eol_q   <= (H_MAX == '0);
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        sof_q   <= 1'b0;
                        eol_q   <= 1'b0;
                    end else if (!stall) begin
                        sof_q <= 1'b0;
                        if (y_wrap) begin
                            state_q <= DRAIN;
                            valid_q <= 1'b0;
                            eol_q   <= 1'b0;
                            drain_q <= DRAIN_LOAD;
                        end else begin
                            eol_q <= (x_nxt == H_MAX);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!stall) begin
                        if (drain_q == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            fcnt_q  <= fcnt_q + FCNT_W'(1);
                        end else begin
                            drain_q <= drain_q - DRAIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    sof_q   <= 1'b0;
                    eol_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_x     = coord.x;
    assign pixel_y     = coord.y;
    assign pixel_valid = valid_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;

endmodule
